// File: rtl/vram_fetch.sv
// Line fetcher: reads LWORDS words per line and unpacks each into HPIX pixel writes into one half of a
// ping-pong pixel buffer. MemReq rises 1 cycle after LineStart; writes follow MemAck by 1 cycle; stalls in WAIT while the next half is still full.
module vram_fetch #(
  parameter  int IWIDTH = 2,
  parameter  int BPP    = 6,
  parameter  int AWIDTH = 16,
  parameter  int LWORDS = 80,
  localparam int HPIX   = 1 << (IWIDTH - 1),
  localparam int WORDW  = BPP * HPIX
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              LineStart,
  input  logic [AWIDTH-1:0] LineAddr,
  input  logic              ReadHalf,
  output logic              MemReq,
  output logic [AWIDTH-1:0] MemAddr,
  input  logic              MemAck,
  input  logic [WORDW-1:0]  MemData,
  output logic              Write,
  output logic [IWIDTH-1:0] WriteIndex,
  output logic [BPP-1:0]    DataOut,
  output logic              Busy,
  output logic              Underrun
);

  localparam int KW = IWIDTH - 1;
  localparam int CW = $clog2(LWORDS + 1);

  typedef enum logic [1:0] {IDLE, REQ, UNPACK, WAIT} state_t;

  state_t            state_q, state_d;
  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [WORDW-1:0]  word_q, word_d;
  logic [KW-1:0]     k_q, k_d;
  logic [CW-1:0]     wcnt_q, wcnt_d;
  logic [1:0]        filled_q, filled_d;
  logic              fill_half_q, fill_half_d;
  logic              underrun_q, underrun_d;
  logic              pend_q, pend_d;
  logic [AWIDTH-1:0] pend_addr_q, pend_addr_d;
  logic              rh_q, rh_d;
  logic              mem_req_q, mem_req_d;
  logic              write_q, write_d;
  logic [IWIDTH-1:0] widx_q, widx_d;
  logic [BPP-1:0]    dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              restart;
  logic [AWIDTH-1:0] restart_addr;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    word_d       = word_q;
    k_d          = k_q;
    wcnt_d       = wcnt_q;
    filled_d     = filled_q;
    fill_half_d  = fill_half_q;
    underrun_d   = underrun_q;
    pend_d       = pend_q;
    pend_addr_d  = pend_addr_q;
    rh_d         = ReadHalf;
    restart      = 1'b0;
    restart_addr = LineAddr;

    // Display moved to the other half: the half it left is free again.
    if (ReadHalf != rh_q) begin
      filled_d[rh_q] = 1'b0;
      if (busy_q && !filled_q[ReadHalf]) underrun_d = 1'b1;
    end
    if (LineStart) underrun_d = 1'b0;

    case (state_q)
      IDLE: restart = LineStart;
      REQ: begin
        if (LineStart) begin
          pend_d      = 1'b1;
          pend_addr_d = LineAddr;
        end
        if (MemAck) begin
          if (pend_q || LineStart) begin
            restart      = 1'b1;
            restart_addr = LineStart ? LineAddr : pend_addr_q;
            pend_d       = 1'b0;
          end else begin
            word_d  = MemData;
            addr_d  = addr_q + AWIDTH'(1);
            wcnt_d  = wcnt_q + CW'(1);
            k_d     = '0;
            state_d = UNPACK;
          end
        end
      end
      UNPACK: begin
        if (LineStart) begin
          restart = 1'b1;
        end else if (k_q == KW'(HPIX - 1)) begin
          // Set after the consumption clear so a simultaneous set wins.
          filled_d[fill_half_q] = 1'b1;
          fill_half_d           = !fill_half_q;
          if (wcnt_q == CW'(LWORDS))          state_d = IDLE;
          else if (!filled_d[fill_half_d])    state_d = REQ;
          else                                state_d = WAIT;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      WAIT: begin
        if (LineStart)                   restart = 1'b1;
        else if (!filled_d[fill_half_q]) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase

    // A restart taken on an acknowledge passes through WAIT so MemReq drops for a cycle.
    if (restart) begin
      addr_d      = restart_addr;
      wcnt_d      = '0;
      filled_d    = '0;
      fill_half_d = 1'b0;
      state_d     = (state_q == REQ) ? WAIT : REQ;
    end

    mem_req_d = (state_d == REQ);
    busy_d    = (state_d != IDLE);
    write_d   = (state_d == UNPACK);
    widx_d    = write_d ? {fill_half_d, k_d} : '0;
    dout_d    = write_d ? word_d[int'(k_d)*BPP +: BPP] : '0;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      word_q      <= '0;
      k_q         <= '0;
      wcnt_q      <= '0;
      filled_q    <= '0;
      fill_half_q <= 1'b0;
      underrun_q  <= 1'b0;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
      rh_q        <= 1'b0;
      mem_req_q   <= 1'b0;
      write_q     <= 1'b0;
      widx_q      <= '0;
      dout_q      <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      word_q      <= word_d;
      k_q         <= k_d;
      wcnt_q      <= wcnt_d;
      filled_q    <= filled_d;
      fill_half_q <= fill_half_d;
      underrun_q  <= underrun_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
      rh_q        <= rh_d;
      mem_req_q   <= mem_req_d;
      write_q     <= write_d;
      widx_q      <= widx_d;
      dout_q      <= dout_d;
      busy_q      <= busy_d;
    end
  end

  assign MemReq     = mem_req_q;
  assign MemAddr    = addr_q;
  assign Write      = write_q;
  assign WriteIndex = widx_q;
  assign DataOut    = dout_q;
  assign Busy       = busy_q;
  assign Underrun   = underrun_q;

endmodule

// File: tb/tb_vram_fetch.sv
// Directed bench for vram_fetch with a 4-word line; expected values are hand-computed.
module tb_vram_fetch;
  localparam int IWIDTH = 2;
  localparam int BPP    = 6;
  localparam int AWIDTH = 16;
  localparam int LWORDS = 4;
  localparam int WORDW  = 12;

  logic              Clk = 1'b0;
  logic              Reset;
  logic              LineStart;
  logic [AWIDTH-1:0] LineAddr;
  logic              ReadHalf;
  logic              MemReq;
  logic [AWIDTH-1:0] MemAddr;
  logic              MemAck;
  logic [WORDW-1:0]  MemData;
  logic              Write;
  logic [IWIDTH-1:0] WriteIndex;
  logic [BPP-1:0]    DataOut;
  logic              Busy;
  logic              Underrun;

  int vectors = 0;
  int miscompares = 0;

  vram_fetch #(.IWIDTH(IWIDTH), .BPP(BPP), .AWIDTH(AWIDTH), .LWORDS(LWORDS)) dut (
    .Clk(Clk), .Reset(Reset), .LineStart(LineStart), .LineAddr(LineAddr),
    .ReadHalf(ReadHalf), .MemReq(MemReq), .MemAddr(MemAddr), .MemAck(MemAck),
    .MemData(MemData), .Write(Write), .WriteIndex(WriteIndex), .DataOut(DataOut),
    .Busy(Busy), .Underrun(Underrun)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_wr(input string tag, input logic [31:0] idx, input logic [31:0] pix);
    chk({tag, "_write"}, 32'(Write), 1);
    chk({tag, "_index"}, 32'(WriteIndex), idx);
    chk({tag, "_data"}, 32'(DataOut), pix);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1; LineStart = 1'b0; LineAddr = '0; ReadHalf = 1'b0; MemAck = 1'b0; MemData = '0;
    step();
    chk("rst_memreq", 32'(MemReq), 0);
    chk("rst_memaddr", 32'(MemAddr), 0);
    chk("rst_write", 32'(Write), 0);
    chk("rst_index", 32'(WriteIndex), 0);
    chk("rst_data", 32'(DataOut), 0);
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_underrun", 32'(Underrun), 0);
    step();
    Reset = 1'b0;
    step(); step(); step();
    chk("idle_memreq", 32'(MemReq), 0);
    chk("idle_busy", 32'(Busy), 0);

    // Basic fetch: two words of 0x0C3 fill both halves, then WAIT.
    LineStart = 1'b1; LineAddr = 16'h0100;
    step();
    LineStart = 1'b0;
    chk("w1_req", 32'(MemReq), 1);
    chk("w1_addr", 32'(MemAddr), 32'h0100);
    chk("w1_busy", 32'(Busy), 1);
    step();
    chk("w1_req_hold", 32'(MemReq), 1);
    chk("w1_addr_hold", 32'(MemAddr), 32'h0100);
    MemAck = 1'b1; MemData = 12'h0C3;
    step();
    MemAck = 1'b0; MemData = '0;
    chk("w1_req_drop", 32'(MemReq), 0);
    chk_wr("w1_px0", 0, 32'h03);
    step();
    chk_wr("w1_px1", 1, 32'h03);
    step();
    chk("w2_nowrite", 32'(Write), 0);
    chk("w2_req", 32'(MemReq), 1);
    chk("w2_addr", 32'(MemAddr), 32'h0101);
    step();
    MemAck = 1'b1; MemData = 12'h0C3;
    step();
    MemAck = 1'b0; MemData = '0;
    chk_wr("w2_px0", 2, 32'h03);
    step();
    chk_wr("w2_px1", 3, 32'h03);
    step();
    chk("wait_req", 32'(MemReq), 0);
    chk("wait_write", 32'(Write), 0);
    chk("wait_busy", 32'(Busy), 1);
    step(); step(); step();
    chk("wait_hold_req", 32'(MemReq), 0);

    // Flow control: display moves to half 1, freeing half 0.
    ReadHalf = 1'b1;
    step();
    chk("w3_req", 32'(MemReq), 1);
    chk("w3_addr", 32'(MemAddr), 32'h0102);
    chk("w3_underrun", 32'(Underrun), 0);
    MemAck = 1'b1; MemData = 12'hA5F;
    step();
    MemAck = 1'b0;
    chk_wr("w3_px0", 0, 32'h1F);
    step();
    chk_wr("w3_px1", 1, 32'h29);
    step();
    chk("w3_wait_req", 32'(MemReq), 0);
    chk("w3_wait_busy", 32'(Busy), 1);

    // Line end: fourth word completes the line.
    ReadHalf = 1'b0;
    step();
    chk("w4_req", 32'(MemReq), 1);
    chk("w4_addr", 32'(MemAddr), 32'h0103);
    MemAck = 1'b1; MemData = 12'h040;
    step();
    MemAck = 1'b0;
    chk_wr("w4_px0", 2, 32'h00);
    step();
    chk_wr("w4_px1", 3, 32'h01);
    step();
    chk("end_busy", 32'(Busy), 0);
    chk("end_req", 32'(MemReq), 0);
    chk("end_write", 32'(Write), 0);
    chk("end_underrun", 32'(Underrun), 0);
    step(); step();
    chk("end_no_fifth_req", 32'(MemReq), 0);

    // Underrun: display toggles while the first word is still outstanding.
    LineStart = 1'b1; LineAddr = 16'h0300;
    step();
    LineStart = 1'b0;
    chk("ur_req", 32'(MemReq), 1);
    chk("ur_clear_start", 32'(Underrun), 0);
    for (int i = 0; i < 10; i++) begin
      ReadHalf = ~ReadHalf;
      step();
    end
    chk("ur_set", 32'(Underrun), 1);
    chk("ur_addr_hold", 32'(MemAddr), 32'h0300);
    MemAck = 1'b1; MemData = 12'h000;
    step();
    MemAck = 1'b0;
    chk_wr("ur_px0", 0, 32'h00);
    chk("ur_sticky", 32'(Underrun), 1);

    // LineStart in UNPACK cycle 0: the second pixel write is suppressed.
    LineStart = 1'b1; LineAddr = 16'h0400;
    step();
    LineStart = 1'b0;
    chk("ab_unpack_write", 32'(Write), 0);
    chk("ab_unpack_req", 32'(MemReq), 1);
    chk("ab_unpack_addr", 32'(MemAddr), 32'h0400);
    chk("ur_cleared", 32'(Underrun), 0);

    // LineStart during REQ, replaced by a second one; ack 3 cycles after the first.
    LineStart = 1'b1; LineAddr = 16'h0250;
    step();
    LineStart = 1'b0;
    chk("ab_req_addr_hold", 32'(MemAddr), 32'h0400);
    step();
    LineStart = 1'b1; LineAddr = 16'h0200;
    step();
    LineStart = 1'b0;
    MemAck = 1'b1; MemData = 12'hFFF;
    step();
    MemAck = 1'b0;
    chk("ab_discard_write", 32'(Write), 0);
    chk("ab_req_gap", 32'(MemReq), 0);
    chk("ab_busy", 32'(Busy), 1);
    step();
    chk("ab_restart_req", 32'(MemReq), 1);
    chk("ab_restart_addr", 32'(MemAddr), 32'h0200);
    chk("ab_restart_write", 32'(Write), 0);

    // Reset in the middle of a request.
    Reset = 1'b1;
    #1;
    chk("mrst_req", 32'(MemReq), 0);
    chk("mrst_addr", 32'(MemAddr), 0);
    chk("mrst_write", 32'(Write), 0);
    chk("mrst_index", 32'(WriteIndex), 0);
    chk("mrst_data", 32'(DataOut), 0);
    chk("mrst_busy", 32'(Busy), 0);
    chk("mrst_underrun", 32'(Underrun), 0);
    step();
    Reset = 1'b0;
    MemAck = 1'b1;
    step(); step();
    MemAck = 1'b0;
    chk("post_rst_req", 32'(MemReq), 0);
    chk("post_rst_busy", 32'(Busy), 0);
    chk("post_rst_write", 32'(Write), 0);
    LineStart = 1'b1; LineAddr = 16'h0010;
    step();
    LineStart = 1'b0;
    chk("post_rst_start_req", 32'(MemReq), 1);
    chk("post_rst_start_addr", 32'(MemAddr), 32'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/vram_fetch.md
VRAM_FETCH -- requirements
Module: vram_fetch

Interface
REQ-001 Parameters SHALL be: IWIDTH, default 2, pixel buffer index width; BPP, default 6, bits per pixel; AWIDTH, default 16, memory address width; LWORDS, default 80, memory words fetched per line.
REQ-002 Derived values SHALL be: HPIX = 2^(IWIDTH-1), the pixels per buffer half and per memory word; WORDW = BPP*HPIX, the memory word width.
REQ-003 Ports, listed as name, direction, width, meaning:
- Clk  in  1  single clock; all logic on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- LineStart  in  1  one-cycle pulse that begins fetching a line.
- LineAddr  in  AWIDTH  first word address of the line; sampled on LineStart.
- ReadHalf  in  1  buffer half currently being displayed (MSB of the display read index).
- MemReq  out  1  memory read request.
- MemAddr  out  AWIDTH  memory word address; valid while MemReq=1.
- MemAck  in  1  memory acknowledge; MemData is valid in the same cycle.
- MemData  in  WORDW  fetched word.
- Write  out  1  pixel buffer write strobe.
- WriteIndex  out  IWIDTH  pixel buffer write index.
- DataOut  out  BPP  pixel written to the buffer.
- Busy  out  1  line fetch in progress.
- Underrun  out  1  sticky display-overtook-fetch flag.

Function
REQ-004 The block SHALL implement a state machine with the states IDLE, REQ, UNPACK and WAIT.
REQ-005 On LineStart, the block SHALL load the address from LineAddr, zero the word counter, clear Filled[1:0], set FillHalf=0, clear Underrun, and enter REQ in the next cycle.
REQ-006 The block SHALL hold MemReq=1 with MemAddr stable throughout REQ, until MemAck=1 is sampled.
REQ-007 MemReq SHALL be 0 in the cycle after the cycle in which MemAck is sampled high.
REQ-008 MemAck SHALL be ignored while MemReq=0.
REQ-009 On acknowledge, the block SHALL latch MemData, increment the address by 1 (wrapping modulo 2^AWIDTH), increment the word counter, and enter UNPACK.
REQ-010 UNPACK SHALL last exactly HPIX cycles; in cycle k (k = 0..HPIX-1) the outputs SHALL be Write=1, WriteIndex={FillHalf, k}, DataOut=word[BPP*k +: BPP].
REQ-011 After the last UNPACK cycle, the block SHALL set Filled[FillHalf]=1 and toggle FillHalf.
REQ-012 After UNPACK, if the word counter equals LWORDS, the next state SHALL be IDLE; otherwise, if Filled[FillHalf]=0, REQ; otherwise, WAIT.
REQ-013 The block SHALL stay in WAIT until Filled[FillHalf]=0, then enter REQ.
REQ-014 Consumption rule: the block SHALL register ReadHalf; on any cycle where ReadHalf differs from its registered value, Filled[previous ReadHalf] SHALL be cleared.
REQ-015 If a half transitions to empty and to filled in the same cycle, the set SHALL win.
REQ-016 When ReadHalf changes to a half H with Filled[H]=0 while Busy=1, Underrun SHALL be set to 1; Underrun SHALL stay 1 until the next LineStart or Reset.
REQ-017 Write SHALL be 0 in every state other than UNPACK.
REQ-018 Busy SHALL be 1 in REQ, UNPACK and WAIT, and 0 in IDLE.
REQ-019 Latency: LineStart at cycle 0 SHALL produce MemReq=1 at cycle 1; MemAck at cycle n SHALL produce Write=1 at cycles n+1..n+HPIX.
REQ-020 LineStart in IDLE, WAIT or UNPACK SHALL take effect immediately; any remaining UNPACK writes SHALL be suppressed from the following cycle.
REQ-021 LineStart in REQ SHALL be held pending until MemAck; that word SHALL be discarded (no writes), and the restart SHALL then use the address from LineAddr latched at the time of the pulse.
REQ-022 A second LineStart while one is pending SHALL replace the latched LineAddr.
REQ-023 With LWORDS words per line, the block SHALL issue exactly LWORDS requests per LineStart, absent aborts.

Reset
REQ-024 Reset=1 SHALL asynchronously force: state IDLE, MemReq=0, MemAddr=0, Write=0, WriteIndex=0, DataOut=0, Busy=0, Underrun=0, Filled=0, FillHalf=0, no pending LineStart, and registered ReadHalf=0.
REQ-025 Reset asserted mid-handshake SHALL drop MemReq within the same cycle, and after release the block SHALL not resume the request.
REQ-026 After Reset is released, the block SHALL remain in IDLE until a LineStart.

Verification
REQ-027 Basic fetch: LineStart with LineAddr=0x0100, MemAck one cycle after each request, MemData=0x0C3 -> MemAddr 0x0100 then 0x0101; writes idx0=0x03, idx1=0x03; then idx2=0x03, idx3=0x03; then WAIT with MemReq=0.
REQ-028 Flow control: hold ReadHalf=0 -> no third request; toggle ReadHalf to 1 -> MemReq=1 with MemAddr=0x0102 next cycle; the writes go to idx0 and idx1.
REQ-029 Line end: LWORDS=4 with ReadHalf toggling freely -> exactly 4 requests; Busy falls after the 4th UNPACK; Underrun=0.
REQ-030 Underrun: toggle ReadHalf every cycle right after LineStart, with MemAck delayed 10 cycles -> Underrun=1 and it remains 1 until the next LineStart clears it.
REQ-031 Abort: LineStart with LineAddr=0x0200 during REQ, MemAck 3 cycles later -> no Write for that word; next MemReq has MemAddr=0x0200. Separately, LineStart in UNPACK cycle 0 -> only 1 write occurs.
REQ-032 Reset during REQ with MemReq=1 -> MemReq=0 immediately, all outputs 0; no MemReq after release until LineStart.
